// File: rtl/capture_ctrl_pkg.sv
// capture_ctrl_pkg: shared state encoding and default parameters for the capture controller
package capture_ctrl_pkg;

    // State encoding of the shadow-compare/restore controller
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MONITOR,
        ST_RESTORE,
        ST_DRAIN
    } state_t;

    localparam int STATE_W            = 2;
    localparam int DEF_WIDTH          = 32;
    localparam int DEF_ERR_CNT_W      = 16;
    localparam int DEF_RECOVER_CYCLES = 2;

endpackage

// File: rtl/capture_err_cnt.sv
// capture_err_cnt: saturating error counter with sync clear; increment wins over clear
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   clr  - clear to zero (loads 1 when coinciding with inc)
//   inc  - count one event, holding at all-ones
//   cnt  - current count
module capture_err_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (inc)
            cnt <= clr ? W'(1) : (&cnt ? cnt : cnt + W'(1));
        else if (clr)
            cnt <= '0;
    end

endmodule

// File: rtl/capture_ctrl.sv
// capture_ctrl: main/shadow flop compare, stall and one-cycle shadow restore on mismatch
// Ports:
//   CK           - clock
//   RST          - synchronous active-high reset
//   EN           - monitoring enable
//   VALID        - monitored stage holds valid data
//   Q_MAIN       - main flop outputs
//   Q_SHADOW     - shadow flop outputs
//   ERR_CLR      - clears ERR_FLAG / ERR_COUNT (and ERR_MASK)
//   STALL        - pipeline stall request
//   RESTORE      - load RESTORE_DATA into main flops this cycle
//   RESTORE_DATA - shadow value captured at the last error
//   ERR_FLAG     - sticky error flag
//   ERR_COUNT    - saturating error count
//   ERR_MASK     - differing bits of the first error (only with CAPTURE_ERR_LOG_EN)
// Optional feature macro: CAPTURE_ERR_LOG_EN
module capture_ctrl
    import capture_ctrl_pkg::*;
#(
    parameter int WIDTH          = DEF_WIDTH,
    parameter int ERR_CNT_W      = DEF_ERR_CNT_W,
    parameter int RECOVER_CYCLES = DEF_RECOVER_CYCLES
) (
    input  logic                 CK,
    input  logic                 RST,
    input  logic                 EN,
    input  logic                 VALID,
    input  logic [WIDTH-1:0]     Q_MAIN,
    input  logic [WIDTH-1:0]     Q_SHADOW,
    input  logic                 ERR_CLR,
    output logic                 STALL,
    output logic                 RESTORE,
    output logic [WIDTH-1:0]     RESTORE_DATA,
    output logic                 ERR_FLAG,
    output logic [ERR_CNT_W-1:0] ERR_COUNT
`ifdef CAPTURE_ERR_LOG_EN
    ,
    output logic [WIDTH-1:0]     ERR_MASK
`endif
);

    // Drain counter holds the remaining DRAIN cycles minus one
    localparam int CW = RECOVER_CYCLES > 2 ? $clog2(RECOVER_CYCLES) : 1;

    state_t        state, state_nxt;
    logic [CW-1:0] drain_cnt, drain_nxt;
    logic          err;

    // Compare is only live in MONITOR; mismatches during recovery are ignored
    assign err = (state == ST_MONITOR) && VALID && (Q_MAIN != Q_SHADOW);

    always_comb begin
        state_nxt = state;
        drain_nxt = drain_cnt;
        case (state)
            ST_IDLE:    state_nxt = EN ? ST_MONITOR : ST_IDLE;
            ST_MONITOR: state_nxt = err ? ST_RESTORE : (EN ? ST_MONITOR : ST_IDLE);
            ST_RESTORE: begin
                if (RECOVER_CYCLES == 1) begin
                    state_nxt = EN ? ST_MONITOR : ST_IDLE;
                end else begin
                    state_nxt = ST_DRAIN;
                    drain_nxt = CW'(RECOVER_CYCLES - 2);
                end
            end
            ST_DRAIN: begin
                if (drain_cnt == '0)
                    state_nxt = EN ? ST_MONITOR : ST_IDLE;
                else
                    drain_nxt = drain_cnt - 1'b1;
            end
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they are true flop outputs
    always_ff @(posedge CK) begin
        if (RST) begin
            state        <= ST_IDLE;
            drain_cnt    <= '0;
            STALL        <= 1'b0;
            RESTORE      <= 1'b0;
            RESTORE_DATA <= '0;
            ERR_FLAG     <= 1'b0;
        end else begin
            state        <= state_nxt;
            drain_cnt    <= drain_nxt;
            STALL        <= (state_nxt == ST_RESTORE) || (state_nxt == ST_DRAIN);
            RESTORE      <= state_nxt == ST_RESTORE;
            if (err)
                RESTORE_DATA <= Q_SHADOW;
            ERR_FLAG     <= err | (ERR_FLAG & ~ERR_CLR);
        end
    end

`ifdef CAPTURE_ERR_LOG_EN
    // Captures only the first error; a clear in the same cycle re-arms it first
    always_ff @(posedge CK) begin
        if (RST)
            ERR_MASK <= '0;
        else if (err && (!ERR_FLAG || ERR_CLR))
            ERR_MASK <= Q_MAIN ^ Q_SHADOW;
        else if (ERR_CLR)
            ERR_MASK <= '0;
    end
`endif

    capture_err_cnt #(.W(ERR_CNT_W)) u_err_cnt (
        .clk (CK),
        .rst (RST),
        .clr (ERR_CLR),
        .inc (err),
        .cnt (ERR_COUNT)
    );

endmodule

// File: tb/tb_capture_ctrl.sv
// tb_capture_ctrl: directed scoreboard bench for capture_ctrl (plus a 2-bit counter instance)
module tb_capture_ctrl;

    logic        CK = 1'b0;
    logic        RST = 1'b1, EN = 1'b0, VALID = 1'b0, ERR_CLR = 1'b0;
    logic [31:0] Q_MAIN = '0, Q_SHADOW = '0;
    logic        STALL, RESTORE, ERR_FLAG;
    logic [31:0] RESTORE_DATA;
    logic [15:0] ERR_COUNT;
    logic        s_stall, s_restore, s_flag;
    logic [31:0] s_data;
    logic [1:0]  s_count;
`ifdef CAPTURE_ERR_LOG_EN
    logic [31:0] ERR_MASK, s_mask;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic        s, r, f;
        logic [31:0] d, m;
        logic [15:0] c;
    } exp_t;
    exp_t sb[$];

    always #5 CK = ~CK;

    capture_ctrl #(.WIDTH(32), .ERR_CNT_W(16), .RECOVER_CYCLES(2)) dut (
        .CK(CK), .RST(RST), .EN(EN), .VALID(VALID), .Q_MAIN(Q_MAIN), .Q_SHADOW(Q_SHADOW),
        .ERR_CLR(ERR_CLR), .STALL(STALL), .RESTORE(RESTORE), .RESTORE_DATA(RESTORE_DATA),
        .ERR_FLAG(ERR_FLAG), .ERR_COUNT(ERR_COUNT)
`ifdef CAPTURE_ERR_LOG_EN
        , .ERR_MASK(ERR_MASK)
`endif
    );

    capture_ctrl #(.WIDTH(32), .ERR_CNT_W(2), .RECOVER_CYCLES(2)) dut_sat (
        .CK(CK), .RST(RST), .EN(EN), .VALID(VALID), .Q_MAIN(Q_MAIN), .Q_SHADOW(Q_SHADOW),
        .ERR_CLR(ERR_CLR), .STALL(s_stall), .RESTORE(s_restore), .RESTORE_DATA(s_data),
        .ERR_FLAG(s_flag), .ERR_COUNT(s_count)
`ifdef CAPTURE_ERR_LOG_EN
        , .ERR_MASK(s_mask)
`endif
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", name, got, exp);
        end
    endtask

    // Drive one cycle of inputs, queue the outputs expected after the sampling edge,
    // then pop and compare once the DUT has produced them.
    task automatic cyc(input string tag, input logic rst, en, v, input logic [31:0] qm, qs,
                       input logic clr, s, r, input logic [31:0] d, input logic f,
                       input logic [15:0] c, input logic [31:0] m);
        exp_t e;
        RST = rst; EN = en; VALID = v; Q_MAIN = qm; Q_SHADOW = qs; ERR_CLR = clr;
        sb.push_back('{tag: tag, s: s, r: r, f: f, d: d, m: m, c: c});
        @(posedge CK);
        #1;
        e = sb.pop_front();
        chk({e.tag, ".stall"}, 32'(STALL), 32'(e.s));
        chk({e.tag, ".restore"}, 32'(RESTORE), 32'(e.r));
        chk({e.tag, ".data"}, RESTORE_DATA, e.d);
        chk({e.tag, ".flag"}, 32'(ERR_FLAG), 32'(e.f));
        chk({e.tag, ".count"}, 32'(ERR_COUNT), 32'(e.c));
        chk({e.tag, ".satcount"}, 32'(s_count), e.c > 16'd3 ? 32'd3 : 32'(e.c));
`ifdef CAPTURE_ERR_LOG_EN
        chk({e.tag, ".mask"}, ERR_MASK, e.m);
`endif
    endtask

    initial begin
        //   tag           rst en v  qm     qs     clr stall rst_o data   flag cnt mask
        cyc("rst1",        1, 1, 1, 32'h1, 32'h3, 0, 0, 0, 32'h0,  0, 0, 32'h0);
        cyc("rst2",        1, 1, 1, 32'h1, 32'h3, 0, 0, 0, 32'h0,  0, 0, 32'h0);
        cyc("idle_ign",    0, 1, 1, 32'h1, 32'h3, 0, 0, 0, 32'h0,  0, 0, 32'h0);
        cyc("err1_rst",    0, 1, 1, 32'h1, 32'h3, 0, 1, 1, 32'h3,  1, 1, 32'h2);
        cyc("err1_drain",  0, 1, 0, 32'h0, 32'h0, 0, 1, 0, 32'h3,  1, 1, 32'h2);
        cyc("clr_alone",   0, 1, 0, 32'h0, 32'h0, 1, 0, 0, 32'h3,  0, 0, 32'h0);
        cyc("pers1",       0, 1, 1, 32'h10, 32'h20, 0, 1, 1, 32'h20, 1, 1, 32'h30);
        cyc("pers2",       0, 1, 1, 32'h10, 32'h20, 0, 1, 0, 32'h20, 1, 1, 32'h30);
        cyc("pers3",       0, 1, 1, 32'h10, 32'h20, 0, 0, 0, 32'h20, 1, 1, 32'h30);
        cyc("pers4",       0, 1, 1, 32'h10, 32'h20, 0, 1, 1, 32'h20, 1, 2, 32'h30);
        cyc("pers5",       0, 1, 1, 32'h10, 32'h20, 0, 1, 0, 32'h20, 1, 2, 32'h30);
        cyc("pers6",       0, 1, 1, 32'h10, 32'h20, 0, 0, 0, 32'h20, 1, 2, 32'h30);
        cyc("pers7",       0, 1, 1, 32'h10, 32'h20, 0, 1, 1, 32'h20, 1, 3, 32'h30);
        cyc("pers_drain",  0, 1, 0, 32'h0, 32'h0, 0, 1, 0, 32'h20, 1, 3, 32'h30);
        cyc("pers_done",   0, 1, 0, 32'h0, 32'h0, 0, 0, 0, 32'h20, 1, 3, 32'h30);
        cyc("sat4",        0, 1, 1, 32'h5, 32'h7, 0, 1, 1, 32'h7,  1, 4, 32'h30);
        cyc("sat4_d",      0, 1, 0, 32'h0, 32'h0, 0, 1, 0, 32'h7,  1, 4, 32'h30);
        cyc("sat4_m",      0, 1, 0, 32'h0, 32'h0, 0, 0, 0, 32'h7,  1, 4, 32'h30);
        cyc("sat5",        0, 1, 1, 32'h5, 32'h7, 0, 1, 1, 32'h7,  1, 5, 32'h30);
        cyc("sat5_d",      0, 1, 0, 32'h0, 32'h0, 0, 1, 0, 32'h7,  1, 5, 32'h30);
        cyc("sat5_m",      0, 1, 0, 32'h0, 32'h0, 0, 0, 0, 32'h7,  1, 5, 32'h30);
        cyc("clr_err",     0, 1, 1, 32'hA, 32'h8, 1, 1, 1, 32'h8,  1, 1, 32'h2);
        cyc("clr_err_d",   0, 1, 0, 32'h0, 32'h0, 0, 1, 0, 32'h8,  1, 1, 32'h2);
        cyc("clr_err_m",   0, 1, 0, 32'h0, 32'h0, 0, 0, 0, 32'h8,  1, 1, 32'h2);
        cyc("clr_only",    0, 1, 0, 32'h0, 32'h0, 1, 0, 0, 32'h8,  0, 0, 32'h0);
        cyc("en_err",      0, 1, 1, 32'h0, 32'hF0, 0, 1, 1, 32'hF0, 1, 1, 32'hF0);
        cyc("en_off_rs",   0, 0, 1, 32'h0, 32'hF0, 0, 1, 0, 32'hF0, 1, 1, 32'hF0);
        cyc("en_off_dr",   0, 0, 1, 32'h0, 32'hF0, 0, 0, 0, 32'hF0, 1, 1, 32'hF0);
        cyc("idle_stay",   0, 0, 1, 32'h0, 32'hF0, 0, 0, 0, 32'hF0, 1, 1, 32'hF0);
        cyc("idle_to_mon", 0, 1, 1, 32'h0, 32'hF0, 0, 0, 0, 32'hF0, 1, 1, 32'hF0);
        cyc("match",       0, 1, 1, 32'h55, 32'h55, 0, 0, 0, 32'hF0, 1, 1, 32'hF0);
        cyc("err_second",  0, 1, 1, 32'h1, 32'h3, 0, 1, 1, 32'h3,  1, 2, 32'hF0);
        cyc("rst_in_rs",   1, 1, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0,  0, 0, 32'h0);
        cyc("post_rst",    0, 1, 1, 32'h1, 32'h3, 0, 0, 0, 32'h0,  0, 0, 32'h0);
        cyc("err_again",   0, 1, 1, 32'h1, 32'h3, 0, 1, 1, 32'h3,  1, 1, 32'h2);
        cyc("into_drain",  0, 1, 0, 32'h0, 32'h0, 0, 1, 0, 32'h3,  1, 1, 32'h2);
        cyc("rst_in_dr",   1, 1, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0,  0, 0, 32'h0);
        cyc("final_idle",  0, 0, 1, 32'h1, 32'h3, 0, 0, 0, 32'h0,  0, 0, 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/capture_ctrl.md
# capture_ctrl

Controller for a bank of main/shadow capture flip-flops on an FPU pipeline stage: compares each main-flop value with its late-sampled shadow copy, and on mismatch stalls the pipeline and drives a one-cycle restore of the shadow value into the main flops. Maintains a sticky error flag and a saturating error counter for characterisation runs. Sits beside the monitored stage registers, between the stage datapath and the pipeline stall network.

## Interface
Parameters:
- WIDTH, 32, number of monitored main/shadow flop pairs
- ERR_CNT_W, 16, error counter width
- RECOVER_CYCLES, 2, total stall cycles per error including the restore cycle (>=1)

Ports:
- CK  in  1  clock; all state updates on posedge CK
- RST  in  1  reset, synchronous, active-high
- EN  in  1  monitoring enable
- VALID  in  1  monitored stage holds valid data this cycle
- Q_MAIN  in  WIDTH  main flop outputs
- Q_SHADOW  in  WIDTH  shadow flop outputs
- ERR_CLR  in  1  clears ERR_FLAG and ERR_COUNT
- STALL  out  1  pipeline stall request
- RESTORE  out  1  load RESTORE_DATA into main flops this cycle
- RESTORE_DATA  out  WIDTH  captured shadow value
- ERR_FLAG  out  1  sticky: at least one error since reset/clear
- ERR_COUNT  out  ERR_CNT_W  saturating error count

## Operation
- States: IDLE, MONITOR, RESTORE, DRAIN.
- IDLE: no compare; EN=1 -> MONITOR next cycle.
- MONITOR: error = VALID & (Q_MAIN != Q_SHADOW). Error -> RESTORE, latch Q_SHADOW into RESTORE_DATA. No error and EN=0 -> IDLE.
- RESTORE: RESTORE=1, STALL=1, 1 cycle. If RECOVER_CYCLES=1 -> MONITOR/IDLE per EN, else -> DRAIN.
- DRAIN: STALL=1 for RECOVER_CYCLES-1 cycles (down-counter), then -> MONITOR if EN else IDLE.
- Compare is ignored in RESTORE/DRAIN; an error there is neither counted nor restored.
- EN deasserted during RESTORE/DRAIN: recovery completes, then IDLE.
- Each error entering RESTORE: ERR_FLAG<=1, ERR_COUNT<=ERR_COUNT+1, saturating at all-ones.
- ERR_CLR alone: ERR_FLAG<=0, ERR_COUNT<=0. ERR_CLR with same-cycle error: error wins, ERR_FLAG=1, ERR_COUNT=1.
- RESTORE_DATA holds its value between errors.

## Timing
- Reset values: state IDLE; STALL=0, RESTORE=0, RESTORE_DATA=0, ERR_FLAG=0, ERR_COUNT=0.
- RST mid-recovery: back to IDLE next edge, STALL dropped immediately after that edge.
- All outputs registered. Error sampled at edge t -> STALL=RESTORE=1 in cycle t+1; STALL deasserts after t+RECOVER_CYCLES; compare resumes in cycle t+RECOVER_CYCLES+1.
- IDLE->MONITOR costs one cycle after EN rises; a mismatch in that first IDLE cycle is ignored.
- Back-to-back errors: minimum spacing RECOVER_CYCLES+1 cycles.

## Configuration
- CAPTURE_ERR_LOG_EN defined: extra output ERR_MASK (WIDTH) = Q_MAIN ^ Q_SHADOW of the first error after reset/ERR_CLR, held until next RST/ERR_CLR; same clear/error priority as ERR_FLAG.
- Undefined: no ERR_MASK port, no mask register; all other behaviour identical.

## Structure
- Package capture_ctrl_pkg: state enum (IDLE, MONITOR, RESTORE, DRAIN), state width constant, default parameter constants.
- One sub-module: capture_err_cnt (saturating counter with sync clear, increment-wins-over-clear, loads 1 on simultaneous clear+increment).
- Comparator and FSM stay in capture_ctrl.

## Test plan
- Reset: RST=1 two cycles with EN=1 and mismatching inputs -> all outputs 0, state IDLE.
- Single error, RECOVER_CYCLES=2: EN=1, VALID=1, Q_MAIN=0x0000_0001, Q_SHADOW=0x0000_0003 at cycle t -> RESTORE=1 at t+1 with RESTORE_DATA=0x0000_0003, STALL=1 at t+1..t+2, ERR_COUNT=1, ERR_FLAG=1.
- Masked compare: persistent mismatch throughout -> errors counted only at t, t+3, t+6; ERR_COUNT=3 after 7 cycles.
- Saturation: ERR_CNT_W=2, five spaced errors -> ERR_COUNT=3, stays 3.
- Clear priority: ERR_CLR concurrent with new error at ERR_COUNT=5 -> ERR_COUNT=1, ERR_FLAG=1; ERR_CLR alone -> 0/0.
- EN/RST mid-recovery: EN=0 in RESTORE -> full RECOVER_CYCLES stall then IDLE; RST in DRAIN -> STALL=0 next cycle, counters 0; with CAPTURE_ERR_LOG_EN, ERR_MASK=0x0000_0002 after first error above.
